// File: rtl/snpu_policy_deck_if.sv
// Command/response bundle between the SNPU command decoder and the policy-deck engine.
// CW must equal $clog2(NCARDS+1) of the attached deck.
interface snpu_policy_deck_if #(
   parameter int IW = 2,
   parameter int CW = 5
);
   logic            op_valid;
   logic            op_ready;
   logic [2:0]      op_code;
   logic [IW-1:0]   op_idx;
   logic            ent_in;
   logic            resp_valid;
   logic            resp_err;
   logic [2*CW-1:0] resp_data;
   logic            busy;

   modport master (
      output op_valid, op_code, op_idx, ent_in,
      input  op_ready, resp_valid, resp_err, resp_data, busy
   );

   modport slave (
      input  op_valid, op_code, op_idx, ent_in,
      output op_ready, resp_valid, resp_err, resp_data, busy
   );
endinterface

// File: rtl/snpu_policy_deck.sv
// Policy-deck engine: STACK/DISCARD/BOARD card deck with an LFSR-driven Fisher-Yates shuffle.
// Optional macro SNPU_DECK_ENTROPY_EN mixes bus.ent_in into the LFSR feedback.
module snpu_policy_deck #(
   parameter int          NCARDS = 17,
   parameter int          NONES  = 11,
   parameter int          IW     = 2,
   parameter logic [15:0] SEED   = 16'hACE1,
   localparam int         CW     = $clog2(NCARDS + 1)
) (
   input logic               clk,
   input logic               rst_n,
   snpu_policy_deck_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHUF, DONE} state_t;
   typedef enum logic [2:0] {
      OP_STATUS, OP_RESET, OP_SHUFFLE, OP_PEEK,
      OP_DISCARD, OP_PLAY, OP_BOARD, OP_RSVD
   } op_t;

   localparam logic [NCARDS-1:0] INIT_DECK = (NCARDS'(1) << NONES) - NCARDS'(1);
   localparam logic [CW-1:0]     FULL      = CW'(NCARDS);

   state_t            state, state_nx;
   logic [NCARDS-1:0] cards, cards_nx;
   logic [CW-1:0]     n_stack, n_discard, ns_nx, nd_nx;
   logic [CW-1:0]     shuf_i, shuf_i_nx;
   logic [CW-1:0]     total, idx, pos, top, j, ones, zeros;
   logic [15:0]       lfsr;
   logic              fb, accept, idx_bad;
   logic              rv_q, rv_nx, err_q, err_nx;
   logic [2*CW-1:0]   data_q, data_nx;
   op_t               op;

   assign op      = op_t'(bus.op_code);
   assign total   = n_stack + n_discard;
   assign idx     = CW'(bus.op_idx);
   assign idx_bad = idx >= n_stack;
   assign accept  = bus.op_valid && (state == IDLE);
   assign pos     = n_stack - CW'(1) - idx;
   assign top     = (op == OP_PLAY) ? total - CW'(1) : n_stack - CW'(1);
   assign j       = lfsr[CW-1:0];

`ifdef SNPU_DECK_ENTROPY_EN
   assign fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5] ^ bus.ent_in;
`else
   logic unused_ent;
   assign unused_ent = bus.ent_in;
   assign fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
`endif

   always_comb begin
      ones  = '0;
      zeros = '0;
      for (int k = 0; k < NCARDS; k++) begin
         if (CW'(k) >= total) begin
            if (cards[k]) ones = ones + CW'(1);
            else          zeros = zeros + CW'(1);
         end
      end
   end

   // Deck update: one command in IDLE, or one Fisher-Yates step per accepted draw in SHUF.
   always_comb begin
      cards_nx  = cards;
      ns_nx     = n_stack;
      nd_nx     = n_discard;
      shuf_i_nx = shuf_i;
      rv_nx     = 1'b0;
      err_nx    = err_q;
      data_nx   = data_q;
      if (accept && op != OP_SHUFFLE) begin
         rv_nx   = 1'b1;
         err_nx  = 1'b0;
         data_nx = '0;
         case (op)
            OP_STATUS: data_nx = {n_stack, n_discard};
            OP_RESET: begin
               cards_nx = INIT_DECK;
               ns_nx    = FULL;
               nd_nx    = '0;
            end
            OP_PEEK, OP_DISCARD, OP_PLAY: begin
               if (idx_bad) begin
                  err_nx = 1'b1;
               end else begin
                  data_nx = {{(2*CW-1){1'b0}}, cards[pos]};
                  if (op != OP_PEEK) begin
                     for (int k = 0; k < NCARDS - 1; k++) begin
                        if (CW'(k) >= pos && CW'(k) < top) cards_nx[k] = cards[k+1];
                     end
                     cards_nx[top] = cards[pos];
                     ns_nx         = n_stack - CW'(1);
                     if (op == OP_DISCARD) nd_nx = n_discard + CW'(1);
                  end
               end
            end
            OP_BOARD: data_nx = {ones, zeros};
            default:  err_nx = 1'b1;
         endcase
      end else if (accept) begin
         ns_nx     = total;
         nd_nx     = '0;
         shuf_i_nx = total - CW'(1);
      end else if (state == SHUF && shuf_i != '0 && j <= shuf_i) begin
         cards_nx[shuf_i] = cards[j];
         cards_nx[j]      = cards[shuf_i];
         shuf_i_nx        = shuf_i - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cards     <= INIT_DECK;
         n_stack   <= FULL;
         n_discard <= '0;
         shuf_i    <= '0;
         lfsr      <= SEED;
         rv_q      <= 1'b0;
         err_q     <= 1'b0;
         data_q    <= '0;
      end else begin
         cards     <= cards_nx;
         n_stack   <= ns_nx;
         n_discard <= nd_nx;
         shuf_i    <= shuf_i_nx;
         lfsr      <= {fb, lfsr[15:1]};
         rv_q      <= rv_nx;
         err_q     <= err_nx;
         data_q    <= data_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept && op == OP_SHUFFLE) state_nx = (total <= CW'(1)) ? DONE : SHUF;
         SHUF: if (shuf_i == '0) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // DONE reports the merged counters directly; otherwise the registered response is shown.
   always_comb begin
      bus.op_ready   = (state == IDLE);
      bus.busy       = (state != IDLE);
      bus.resp_valid = rv_q;
      bus.resp_err   = err_q;
      bus.resp_data  = data_q;
      if (state == DONE) begin
         bus.resp_valid = 1'b1;
         bus.resp_err   = 1'b0;
         bus.resp_data  = {n_stack, n_discard};
      end
   end

endmodule

// File: tb/tb_snpu_policy_deck.sv
// Randomized self-checking bench for snpu_policy_deck against a queue-based deck model.
// Expects SNPU_DECK_ENTROPY_EN undefined.
module tb_snpu_policy_deck;

   localparam int          NCARDS = 17;
   localparam int          NONES  = 11;
   localparam int          IW     = 2;
   localparam int          CW     = $clog2(NCARDS + 1);
   localparam logic [15:0] SEED   = 16'hACE1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   snpu_policy_deck_if #(.IW(IW), .CW(CW)) bus ();

   snpu_policy_deck #(.NCARDS(NCARDS), .NONES(NONES), .IW(IW), .SEED(SEED)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   bit          m_deck[$];
   int          m_ns, m_nd;
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsrStep(input logic [15:0] l);
      logic f;
      f = l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11];
      return {f, l[15:1]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= SEED;
      else        m_lfsr <= lfsrStep(m_lfsr);
   end

   function automatic logic [31:0] pack(input int a, input int b);
      logic [2*CW-1:0] r;
      r = {CW'(a), CW'(b)};
      return 32'(r);
   endfunction

   task automatic modelReset();
      m_deck.delete();
      for (int i = 0; i < NCARDS; i++) m_deck.push_back(i < NONES);
      m_ns = NCARDS;
      m_nd = 0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One non-shuffle command: model prediction, drive, then check the response cycle.
   task automatic applyStimulus(input int code, input int idx);
      int  p, ones, zeros;
      bit  card;
      logic [31:0] e_data;
      logic        e_err;
      e_data = '0;
      e_err  = 1'b0;
      case (code)
         0: e_data = pack(m_ns, m_nd);
         1: modelReset();
         3, 4, 5: begin
            if (idx >= m_ns) begin
               e_err = 1'b1;
            end else begin
               p      = m_ns - 1 - idx;
               card   = m_deck[p];
               e_data = 32'(card);
               if (code != 3) begin
                  m_deck.delete(p);
                  if (code == 4) begin
                     m_deck.insert(m_ns - 1, card);
                     m_nd++;
                  end else begin
                     m_deck.insert(m_ns + m_nd - 1, card);
                  end
                  m_ns--;
               end
            end
         end
         6: begin
            ones  = 0;
            zeros = 0;
            for (int k = m_ns + m_nd; k < NCARDS; k++) begin
               if (m_deck[k]) ones++;
               else           zeros++;
            end
            e_data = pack(ones, zeros);
         end
         default: e_err = 1'b1;
      endcase
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op_code  = 3'(code);
      bus.op_idx   = IW'(idx);
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      checkOutput($sformatf("op%0d_valid", code), 32'(bus.resp_valid), 32'd1);
      checkOutput($sformatf("op%0d_err", code), 32'(bus.resp_err), 32'(e_err));
      if (!e_err) checkOutput($sformatf("op%0d_data", code), 32'(bus.resp_data), e_data);
   endtask

   // Shuffle with optional dropped commands; rst_at >= 0 pulses reset in that SHUF cycle.
   task automatic doShuffle(input bit noise, input int rst_at);
      int          tot, i, j, nsh, guard;
      bit          t;
      logic [15:0] l;
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op_code  = 3'd2;
      bus.op_idx   = '0;
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      tot   = m_ns + m_nd;
      m_ns  = tot;
      m_nd  = 0;
      l     = m_lfsr;
      i     = tot - 1;
      nsh   = 0;
      guard = 0;
      if (tot > 1) begin
         while (i != 0 && guard < 4000) begin
            j = int'(l[CW-1:0]);
            if (j <= i) begin
               t         = m_deck[i];
               m_deck[i] = m_deck[j];
               m_deck[j] = t;
               i--;
            end
            l = lfsrStep(l);
            nsh++;
            guard++;
         end
         nsh++;
      end
      for (int c = 0; c < nsh; c++) begin
         checkOutput("shuf_busy", 32'(bus.busy), 32'd1);
         checkOutput("shuf_ready", 32'(bus.op_ready), 32'd0);
         if (c == rst_at) begin
            @(negedge clk);
            rst_n        = 1'b0;
            bus.op_valid = 1'b0;
            #1;
            checkOutput("rst_busy", 32'(bus.busy), 32'd0);
            checkOutput("rst_ready", 32'(bus.op_ready), 32'd1);
            modelReset();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
         bus.op_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.op_code  = 3'($urandom_range(0, 7));
         bus.op_idx   = IW'($urandom_range(0, 3));
         @(posedge clk);
         #1;
      end
      checkOutput("done_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("done_err", 32'(bus.resp_err), 32'd0);
      checkOutput("done_data", 32'(bus.resp_data), pack(m_ns, 0));
      checkOutput("done_ready", 32'(bus.op_ready), 32'd0);
      @(negedge clk);
      bus.op_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_ready", 32'(bus.op_ready), 32'd1);
      checkOutput("post_busy", 32'(bus.busy), 32'd0);
      checkOutput("post_valid", 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      int r, code;
      bus.op_valid = 1'b0;
      bus.op_code  = '0;
      bus.op_idx   = '0;
      bus.ent_in   = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready", 32'(bus.op_ready), 32'd1);
      checkOutput("rst_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("rst_err", 32'(bus.resp_err), 32'd0);
      checkOutput("rst_data", 32'(bus.resp_data), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(3, 0);
      applyStimulus(0, 0);
      applyStimulus(6, 0);

      applyStimulus(5, 0);
      applyStimulus(4, 0);
      applyStimulus(0, 0);
      applyStimulus(6, 0);

      doShuffle(1'b1, -1);
      applyStimulus(0, 0);

      applyStimulus(1, 0);
      applyStimulus(3, 3);
      for (int k = 0; k < 15; k++) applyStimulus(4, 0);
      applyStimulus(0, 0);
      applyStimulus(3, 2);
      applyStimulus(0, 0);

      doShuffle(1'b0, 6);
      applyStimulus(0, 0);
      checkOutput("after_rst_busy", 32'(bus.busy), 32'd0);

      applyStimulus(7, 0);
      applyStimulus(3, 0);
      applyStimulus(3, 1);
      @(posedge clk);
      #1;
      checkOutput("idle_valid", 32'(bus.resp_valid), 32'd0);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 39);
         if      (r < 2)  code = 1;
         else if (r < 5)  code = 2;
         else if (r < 8)  code = 0;
         else if (r < 16) code = 3;
         else if (r < 27) code = 4;
         else if (r < 33) code = 5;
         else if (r < 38) code = 6;
         else             code = 7;
         if (code == 2) doShuffle(1'($urandom_range(0, 1)), -1);
         else           applyStimulus(code, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/snpu_policy_deck.md
# snpu_policy_deck

- Parametrised policy-deck engine for the SNPU game core.
- Holds a deck of `NCARDS` one-bit cards, split into three contiguous regions: STACK, DISCARD and BOARD.
- Executes one deck operation per handshake: reset, shuffle, peek, discard, play, board count, status.
- Sits between the SNPU command decoder and the pin-level output mux. Shuffling uses an internal free-running 16-bit LFSR.

## Interface
Parameters:
- `NCARDS`, 17: total cards; legal range 2..31.
- `NONES`, 11: number of 1-cards, ≤ `NCARDS`.
- `IW`, 2: width of the operation index argument.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `CW` (derived): `$clog2(NCARDS+1)`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  command present.
- `op_ready`  out  1  block can accept a command.
- `op_code`  in  3  operation; encodings under Operation.
- `op_idx`  in  IW  hand index, counted from the top of the stack.
- `ent_in`  in  1  external entropy bit; used only with the macro.
- `resp_valid`  out  1  one-cycle pulse, response valid.
- `resp_err`  out  1  qualifies `resp_valid`; 1 = command rejected, no state change.
- `resp_data`  out  2*CW  result payload.
- `busy`  out  1  shuffle in progress.

## Operation
Deck layout:
- Card array `cards[NCARDS-1:0]`, counters `n_stack` and `n_discard`, each CW bits.
- STACK = `[0, n_stack)`; top card = `n_stack-1`.
- DISCARD = `[n_stack, n_stack+n_discard)`.
- BOARD = remainder, up to `NCARDS-1`.

Opcodes:
- 0 STATUS: data = `{n_stack, n_discard}`.
- 1 RESET_DECK: same deck state as hardware reset; data = 0.
- 2 SHUFFLE: multi-cycle. Merges DISCARD into STACK, then applies Fisher–Yates over `[0, n_stack+n_discard)`. On completion `n_stack += n_discard`, `n_discard = 0`. Data = new `{n_stack, n_discard}`.
- 3 PEEK: data[0] = `cards[n_stack-1-op_idx]`; all other data bits are 0.
- 4 DISCARD: takes card p = `n_stack-1-op_idx`. Rotates `[p, n_stack-1]` down by one, so the removed card lands at `n_stack-1`. Then `n_stack--`, `n_discard++`. Data = the moved card.
- 5 PLAY: takes card p = `n_stack-1-op_idx`. Rotates `[p, n_stack+n_discard-1]` down by one, so the card lands at `n_stack+n_discard-1` as the lowest BOARD card. Then `n_stack--`. Data = the moved card.
- 6 BOARD: data = `{ones, zeros}` counted over the BOARD region, CW bits each.
- 7: reserved; always returns error.

Errors:
- Ops 3/4/5 with `op_idx >= n_stack` → `resp_err=1`, state unchanged.

Shuffle FSM (IDLE → SHUF → DONE → IDLE):
- SHUF: i starts at `n_stack+n_discard-1`.
- Each cycle, j = LFSR low `CW` bits.
- If j > i, the draw is rejected; retry next cycle.
- Otherwise swap `cards[i]` and `cards[j]` and decrement i.
- Leave SHUF when i == 0. An empty or one-card range goes straight to DONE.
- Card popcount is invariant under every operation except RESET_DECK.

LFSR:
- Polynomial x^16+x^14+x^13+x^11+1, shifts every cycle in all states.

## Timing
Reset values:
- `cards[i]=1` for i < `NONES`, else 0.
- `n_stack=NCARDS`, `n_discard=0`.
- LFSR = `SEED`.
- `op_ready=1`; `resp_valid`, `resp_err`, `resp_data`, `busy` all 0.

Handshake and latency:
- A command is accepted on a rising edge with `op_valid & op_ready`.
- Non-shuffle ops: state and response update on the accepting edge; `resp_valid` is high for exactly the following cycle.
- SHUFFLE: `op_ready=0` and `busy=1` from the accepting edge until DONE. `resp_valid` pulses in DONE. `op_ready` returns 1 the cycle after.
- Minimum shuffle latency is k+1 cycles for a k-card range.
- `op_valid` while `op_ready=0` is ignored, not queued.

Reset mid-operation:
- `rst_n` low at any point, including mid-shuffle, clears everything asynchronously. The deck returns to its reset arrangement.

## Configuration
- `SNPU_DECK_ENTROPY_EN` defined: LFSR feedback bit is XORed with `ent_in` every cycle.
- Undefined: `ent_in` is ignored and the LFSR sequence is fully deterministic from `SEED`.
- All test-plan expectations assume the macro is undefined.

## Test plan
1. Reset, then PEEK idx0 → data=0, err=0; STATUS → `{17,0}`; BOARD → `{0,0}`.
2. From reset: PLAY idx0 → data 0; then DISCARD idx0 → data 0; then STATUS → `{15,1}`; BOARD → ones=0, zeros=1.
3. From reset: PEEK idx3 → data 0, err=0. Then DISCARD ×15 → STATUS `{2,15}`; PEEK idx2 → err=1, STATUS unchanged.
4. From state `{15,1}`: SHUFFLE → `busy=1`, `op_ready=0` for ≥17 cycles; response `{16,0}`; 11 ones across `cards[15:0]`; `op_valid` pulses during the shuffle are dropped.
5. `rst_n` low for one cycle mid-shuffle → immediately STATUS `{17,0}`, `busy=0`, `op_ready=1`.
6. Op 7 → err=1; two back-to-back PEEKs on consecutive cycles → two consecutive `resp_valid` pulses.
